// File: rtl/riscv_pkg.sv
// Shared types and sizing for the RV32IM integer register file.
// Write ports are described as {en, addr, data} so ALU/LSU buses can travel as one struct.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic             en;
    reg_addr_t        addr;
    logic [XLEN-1:0]  data;
  } wr_port_t;

  // True when a write port targets a real (non-x0) register equal to addr.
  function automatic logic port_hits(input logic en, input reg_addr_t waddr, input reg_addr_t addr);
    return en && (waddr == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Busy-bit scoreboard: issue reserves rd next cycle, either write port releases it, newer issue wins.
// Busy queries are combinational and masked by any same-cycle write to the queried register.
module riscv_regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      issue_vld,
  input  reg_addr_t issue_rd,
  input  logic      alu_wr_en,
  input  reg_addr_t alu_wr_addr,
  input  logic      lsu_wr_en,
  input  reg_addr_t lsu_wr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      issue_rd_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  function automatic logic wr_hit(input reg_addr_t addr);
    return port_hits(alu_wr_en, alu_wr_addr, addr) || port_hits(lsu_wr_en, lsu_wr_addr, addr);
  endfunction

  // A write is bypassable, so a register being written this cycle no longer reads as busy.
  function automatic logic busy_now(input reg_addr_t addr);
    return (addr != '0) && busy_q[addr] && !wr_hit(addr);
  endfunction

  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (wr_hit(reg_addr_t'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    // Applied after the clears: the issuing instruction is newer than the retiring one.
    if (issue_vld && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy      = busy_now(rs1_addr);
  assign rs2_busy      = busy_now(rs2_addr);
  assign issue_rd_busy = busy_now(issue_rd);

endmodule

// File: rtl/riscv_regfile.sv
// RV32IM integer register file: 2 bypassed combinational reads, ALU+LSU writes commit at posedge.
// No backpressure; issue stalls itself on issue_rd_busy, instret counts done pulses (64-bit wrap).
module riscv_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic            clock,
  input  logic            reset,
  input  reg_addr_t       rd_rs1_addr,
  input  reg_addr_t       rd_rs2_addr,
  output logic [XLEN-1:0] rd_rs1_data,
  output logic [XLEN-1:0] rd_rs2_data,
  output logic            rd_rs1_busy,
  output logic            rd_rs2_busy,
  input  logic            issue_vld,
  input  reg_addr_t       issue_rd,
  output logic            issue_rd_busy,
  input  logic            alu_wr_en,
  input  reg_addr_t       alu_wr_addr,
  input  logic [XLEN-1:0] alu_wr_data,
  input  logic            alu_done,
  input  logic            lsu_wr_en,
  input  reg_addr_t       lsu_wr_addr,
  input  logic [XLEN-1:0] lsu_wr_data,
  input  logic            lsu_done,
  output logic [63:0]     instret,
  output logic            wr_collision
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [63:0]     instret_q;
  logic            wr_collision_q;
  logic            alu_commit;
  logic            lsu_commit;

  assign alu_commit = port_hits(alu_wr_en, alu_wr_addr, alu_wr_addr);
  assign lsu_commit = port_hits(lsu_wr_en, lsu_wr_addr, lsu_wr_addr);

  // LSU has priority on the bypass to match which value the array keeps on a collision.
  function automatic logic [XLEN-1:0] read_port(input reg_addr_t addr);
    if (addr == '0) begin
      return '0;
    end
    if (lsu_wr_en && (lsu_wr_addr == addr)) begin
      return lsu_wr_data;
    end
    if (alu_wr_en && (alu_wr_addr == addr)) begin
      return alu_wr_data;
    end
    return regs_q[addr];
  endfunction

  assign rd_rs1_data = read_port(rd_rs1_addr);
  assign rd_rs2_data = read_port(rd_rs2_addr);

  // Entry 0 is only ever written by reset, so x0 stays zero in storage as well.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (alu_commit) begin
        regs_q[alu_wr_addr] <= alu_wr_data;
      end
      if (lsu_commit) begin
        regs_q[lsu_wr_addr] <= lsu_wr_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_collision_q <= 1'b0;
      instret_q      <= '0;
    end else begin
      if (alu_commit && lsu_commit && (alu_wr_addr == lsu_wr_addr)) begin
        wr_collision_q <= 1'b1;
      end
      instret_q <= instret_q + {63'd0, alu_done} + {63'd0, lsu_done};
    end
  end

  assign instret      = instret_q;
  assign wr_collision = wr_collision_q;

  riscv_regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .issue_vld     (issue_vld),
    .issue_rd      (issue_rd),
    .alu_wr_en     (alu_wr_en),
    .alu_wr_addr   (alu_wr_addr),
    .lsu_wr_en     (lsu_wr_en),
    .lsu_wr_addr   (lsu_wr_addr),
    .rs1_addr      (rd_rs1_addr),
    .rs2_addr      (rd_rs2_addr),
    .rs1_busy      (rd_rs1_busy),
    .rs2_busy      (rd_rs2_busy),
    .issue_rd_busy (issue_rd_busy)
  );

endmodule
